// File: rtl/spi_slave_burst.sv
// ----------------------------------------------------------------------------
// spi_slave_burst
//   SPI slave for the stepper controller's Raspberry Pi link. It oversamples
//   CS/SCK/MOSI in the system clock domain and supports all four SPI modes.
//   Words of BC bits can be streamed back to back while CS stays low.
//
//   Parameters
//     BC          bits per word (2..32)
//     CPOL        SCK idle level
//     CPHA        0: sample on leading edge, launch on trailing edge
//                 1: launch on leading edge, sample on trailing edge
//     SYNC_STAGES depth of the input synchronisers (>= 2)
//
//   Ports
//     clk, rst_n  system clock, asynchronous active-low reset
//     cs, sck     chip select (active low) and SPI clock from the master
//     mosi        master-out data
//     miso        slave-out data (TX shifter MSB)
//     tx_data     next word to send, captured when tx_load is raised
//     tx_load     one-cycle pulse: tx_data captured into the TX shifter
//     rx_data     last complete received word, held until the next one
//     rx_valid    one-cycle pulse: rx_data updated
//     busy        high while the synchronised cs is low
//     abort       one-cycle pulse: cs released in the middle of a word
//
//   Optional feature
//     SPI_SLAVE_MISO_TRISTATE_EN  when defined, miso floats (1'bz) while the
//                                 slave is deselected; otherwise it drives 0.
// ----------------------------------------------------------------------------
module spi_slave_burst #(
    parameter int unsigned BC          = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          sck,
    input  logic          mosi,
    output logic          miso,
    input  logic [BC-1:0] tx_data,
    output logic          tx_load,
    output logic [BC-1:0] rx_data,
    output logic          rx_valid,
    output logic          busy,
    output logic          abort
);

    localparam int unsigned    CW       = (BC > 2) ? $clog2(BC) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(BC - 1);

    // Synchronisers plus one delayed copy of cs/sck for edge detection.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;

    logic cs_s;
    logic sck_s;
    logic mosi_s;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Reset values match an idle bus so leaving reset never looks like an edge.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sck_sync  <= {SYNC_STAGES{CPOL}};
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= CPOL;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
        end
    end

    // Leading edge leaves the idle level, trailing edge returns to it.
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic launch_edge;
    logic cs_fall;
    logic cs_rise;
    logic active;

    assign lead_edge   = (sck_d == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_d != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign launch_edge = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_d  & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;
    // SCK edges count only once cs has been low for a full cycle, so an edge
    // coinciding with the cs transition itself is dropped.
    assign active      = ~cs_d & ~cs_s;

    logic [BC-1:0] tx_sh;
    logic [BC-1:0] rx_sh;
    logic [BC-1:0] rx_next;
    logic [CW-1:0] bit_cnt;
    logic          reload_pending;

    assign rx_next = {rx_sh[BC-2:0], mosi_s};

    // NOTE: the shifters and the received word sit in ordinary flops, not a
    // memory array, so they take the asynchronous reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh          <= '0;
            rx_sh          <= '0;
            rx_data        <= '0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            tx_load        <= 1'b0;
            rx_valid       <= 1'b0;
            busy           <= 1'b0;
            abort          <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            abort    <= 1'b0;

            if (cs_fall) begin
                busy    <= 1'b1;
                bit_cnt <= '0;
                if (!CPHA) begin
                    // First bit must be on miso before the first sample edge.
                    tx_sh          <= tx_data;
                    tx_load        <= 1'b1;
                    reload_pending <= 1'b0;
                end else begin
                    // First bit is launched by the first leading edge.
                    reload_pending <= 1'b1;
                end
            end else if (cs_rise) begin
                busy           <= 1'b0;
                abort          <= (bit_cnt != '0);
                bit_cnt        <= '0;
                reload_pending <= 1'b0;
            end else if (active) begin
                if (sample_edge) begin
                    rx_sh <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data        <= rx_next;
                        rx_valid       <= 1'b1;
                        bit_cnt        <= '0;
                        reload_pending <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (launch_edge) begin
                    if (reload_pending) begin
                        tx_sh          <= tx_data;
                        tx_load        <= 1'b1;
                        reload_pending <= 1'b0;
                    end else begin
                        tx_sh <= {tx_sh[BC-2:0], 1'b0};
                    end
                end
            end
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = cs_s ? 1'bz : tx_sh[BC-1];
`else
    assign miso = cs_s ? 1'b0 : tx_sh[BC-1];
`endif

endmodule

// File: tb/tb_spi_slave_burst.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_burst
//   Three slaves side by side: mode 0 / 8 bit, mode 3 / 8 bit, mode 1 / 16 bit.
//   A behavioural master shifts whole words MSB first, an upstream model feeds
//   tx_data from a queue on each tx_load, and a monitor records rx words,
//   tx_load and abort pulses. Expected words are the ones the bench chose.
// ----------------------------------------------------------------------------
module tb_spi_slave_burst;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic cs_m   [3];
    logic sck_m  [3];
    logic mosi_m [3];

    logic [7:0]  tx0 = '0;
    logic [7:0]  tx1 = '0;
    logic [15:0] tx2 = '0;
    wire  [7:0]  rxd0;
    wire  [7:0]  rxd1;
    wire  [15:0] rxd2;
    wire  [15:0] rx_data_m [3];
    wire         miso_m     [3];
    wire         tx_load_m  [3];
    wire         rx_valid_m [3];
    wire         busy_m     [3];
    wire         abort_m    [3];

    assign rx_data_m[0] = {8'h00, rxd0};
    assign rx_data_m[1] = {8'h00, rxd1};
    assign rx_data_m[2] = rxd2;

    spi_slave_burst #(.BC(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_mode0 (
        .clk(clk), .rst_n(rst_n), .cs(cs_m[0]), .sck(sck_m[0]), .mosi(mosi_m[0]),
        .miso(miso_m[0]), .tx_data(tx0), .tx_load(tx_load_m[0]), .rx_data(rxd0),
        .rx_valid(rx_valid_m[0]), .busy(busy_m[0]), .abort(abort_m[0]));

    spi_slave_burst #(.BC(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_mode3 (
        .clk(clk), .rst_n(rst_n), .cs(cs_m[1]), .sck(sck_m[1]), .mosi(mosi_m[1]),
        .miso(miso_m[1]), .tx_data(tx1), .tx_load(tx_load_m[1]), .rx_data(rxd1),
        .rx_valid(rx_valid_m[1]), .busy(busy_m[1]), .abort(abort_m[1]));

    spi_slave_burst #(.BC(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_mode1 (
        .clk(clk), .rst_n(rst_n), .cs(cs_m[2]), .sck(sck_m[2]), .mosi(mosi_m[2]),
        .miso(miso_m[2]), .tx_data(tx2), .tx_load(tx_load_m[2]), .rx_data(rxd2),
        .rx_valid(rx_valid_m[2]), .busy(busy_m[2]), .abort(abort_m[2]));

    function automatic int bc_of(input int i);
        return (i == 2) ? 16 : 8;
    endfunction
    function automatic logic pol_of(input int i);
        return (i == 1);
    endfunction
    function automatic logic pha_of(input int i);
        return (i != 0);
    endfunction

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- upstream model and output monitor ----------------
    logic [15:0] up_q [3][$];
    logic [15:0] rxq  [3][$];
    int          n_load  [3] = '{0, 0, 0};
    int          n_abort [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (rx_valid_m[g]) rxq[g].push_back(rx_data_m[g]);
                if (tx_load_m[g]) begin
                    n_load[g]++;
                    if (up_q[g].size() > 0) void'(up_q[g].pop_front());
                end
                if (abort_m[g]) n_abort[g]++;
            end
            tx0 = (up_q[0].size() > 0) ? up_q[0][0][7:0] : 8'h00;
            tx1 = (up_q[1].size() > 0) ? up_q[1][0][7:0] : 8'h00;
            tx2 = (up_q[2].size() > 0) ? up_q[2][0]      : 16'h0000;
        end
    end

    // ---------------- behavioural master ----------------
    logic [15:0] m_send [$];   // words the master shifts out on mosi
    logic [15:0] e_tx   [$];   // words upstream offers, expected on miso
    logic [15:0] m_got  [$];   // complete words the master read on miso

    task automatic xfer(input int i, input int nbits);
        int          bc;
        int          h;
        int          l0;
        logic [15:0] w;
        logic [15:0] cur_in;
        bc     = bc_of(i);
        cur_in = '0;
        l0     = n_load[i];
        cs_m[i] = 1'b0;
        wait_clks(8);
        check($sformatf("busy_i%0d", i), busy_m[i], 1'b1);
        // Only CPHA=0 fetches a word as soon as cs falls.
        check($sformatf("cs_fall_load_i%0d", i), n_load[i] - l0, pha_of(i) ? 0 : 1);
        for (int k = 0; k < nbits; k++) begin
            w = m_send[k / bc];
            h = $urandom_range(6, 9);
            if (!pha_of(i)) begin
                mosi_m[i] = w[bc - 1 - (k % bc)];
                wait_clks(h);
                cur_in = {cur_in[14:0], miso_m[i]};
                sck_m[i] = ~pol_of(i);
                wait_clks(h);
                sck_m[i] = pol_of(i);
            end else begin
                sck_m[i]  = ~pol_of(i);
                mosi_m[i] = w[bc - 1 - (k % bc)];
                wait_clks(h);
                cur_in = {cur_in[14:0], miso_m[i]};
                sck_m[i] = pol_of(i);
                wait_clks(h);
            end
            if ((k % bc) == bc - 1)
                m_got.push_back((bc == 8) ? {8'h00, cur_in[7:0]} : cur_in);
        end
        wait_clks(8);
        cs_m[i] = 1'b1;
        wait_clks(10);
    endtask

    // Full-word transfer of m_send with e_tx offered upstream.
    task automatic run_words(input int i, input string name);
        int n;
        int r0;
        int l0;
        int a0;
        n = m_send.size();
        foreach (e_tx[j]) up_q[i].push_back(e_tx[j]);
        m_got.delete();
        r0 = rxq[i].size();
        l0 = n_load[i];
        a0 = n_abort[i];
        xfer(i, n * bc_of(i));
        check({name, "_rx_count"}, rxq[i].size() - r0, n);
        // CPHA=0 also preloads on the trailing edge after the last bit.
        check({name, "_tx_loads"}, n_load[i] - l0, n + (pha_of(i) ? 0 : 1));
        check({name, "_abort"}, n_abort[i] - a0, 0);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_rx_word%0d", name, j), rxq[i][r0 + j], m_send[j]);
            check($sformatf("%s_miso_word%0d", name, j), m_got[j], e_tx[j]);
        end
        check({name, "_rx_data"}, rx_data_m[i], m_send[n - 1]);
        check({name, "_busy_idle"}, busy_m[i], 1'b0);
    endtask

    task automatic check_reset_outputs(input int i, input string name);
        check({name, "_rx_data"},  rx_data_m[i],  16'h0000);
        check({name, "_rx_valid"}, rx_valid_m[i], 1'b0);
        check({name, "_tx_load"},  tx_load_m[i],  1'b0);
        check({name, "_busy"},     busy_m[i],     1'b0);
        check({name, "_abort"},    abort_m[i],    1'b0);
        check({name, "_miso"},     miso_m[i],     IDLE_MISO);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          n;
        int          r0;
        int          l0;
        int          a0;
        logic [15:0] mask;

        for (int i = 0; i < 3; i++) begin
            cs_m[i]   = 1'b1;
            sck_m[i]  = pol_of(i);
            mosi_m[i] = 1'b0;
        end
        rst_n = 1'b0;
        wait_clks(3);
        for (int i = 0; i < 3; i++) check_reset_outputs(i, $sformatf("por_i%0d", i));
        rst_n = 1'b1;
        wait_clks(5);

        // Mode 0: send 0xA5, upstream offers 0x3C.
        m_send = '{16'h00A5};
        e_tx   = '{16'h003C};
        run_words(0, "mode0");

        // Mode 3 burst of three words.
        m_send = '{16'h0011, 16'h0022, 16'h0033};
        e_tx   = '{16'h00AA, 16'h00BB, 16'h00CC};
        run_words(1, "mode3_burst");

        // Mode 1, 16-bit words; master samples on falling edges.
        m_send = '{16'hBEEF};
        e_tx   = '{16'h1234};
        run_words(2, "mode1_w16");

        // cs released after 3 bits: one abort, no word, rx_data held.
        m_send = '{16'h00FF};
        up_q[0].push_back(16'h0077);
        r0 = rxq[0].size();
        a0 = n_abort[0];
        xfer(0, 3);
        check("abort_pulses", n_abort[0] - a0, 1);
        check("abort_no_rx", rxq[0].size() - r0, 0);
        check("abort_rx_hold", rx_data_m[0], 16'h00A5);

        m_send = '{16'h005A};
        e_tx   = '{16'h00C3};
        run_words(0, "after_abort");

        // Reset in the middle of a word.
        up_q[0].push_back(16'h0099);
        cs_m[0] = 1'b0;
        wait_clks(8);
        for (int k = 0; k < 4; k++) begin
            mosi_m[0] = 1'b1;
            wait_clks(7);
            sck_m[0] = 1'b1;
            wait_clks(7);
            sck_m[0] = 1'b0;
        end
        wait_clks(3);
        check("pre_reset_busy", busy_m[0], 1'b1);
        rst_n   = 1'b0;
        cs_m[0] = 1'b1;
        #1;
        check_reset_outputs(0, "mid_reset");
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(4);

        // SCK toggling while deselected must be ignored.
        r0 = rxq[0].size();
        l0 = n_load[0];
        a0 = n_abort[0];
        for (int k = 0; k < 5; k++) begin
            sck_m[0]  = 1'b1;
            mosi_m[0] = k[0];
            wait_clks(6);
            sck_m[0] = 1'b0;
            wait_clks(6);
        end
        check("idle_sck_rx", rxq[0].size() - r0, 0);
        check("idle_sck_load", n_load[0] - l0, 0);
        check("idle_sck_abort", n_abort[0] - a0, 0);
        check("idle_sck_miso", miso_m[0], IDLE_MISO);
        check("idle_sck_rx_data", rx_data_m[0], 16'h0000);

        m_send = '{16'h003A};
        e_tx   = '{16'h006E};
        run_words(0, "after_reset");

        // Random bursts on every mode.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                n    = $urandom_range(1, 4);
                mask = (bc_of(i) == 8) ? 16'h00FF : 16'hFFFF;
                m_send.delete();
                e_tx.delete();
                repeat (n) begin
                    m_send.push_back(16'($urandom) & mask);
                    e_tx.push_back(16'($urandom) & mask);
                end
                run_words(i, $sformatf("rand%0d_i%0d", r, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
